seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode seven-segment display. All digits share one BCD-to-segment decoder. The block double-buffers a packed BCD value, steps through the digits at a fixed refresh rate and drives the shared decoder's bcd input, the active-low digit enables and the decimal point. Each digit slot starts with an anti-ghosting blank guard, and leading zeros can optionally be suppressed.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant
REFRESH_DIV, 1000, clock cycles per digit slot; must be greater than BLANK_CYCLES
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (at least 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display dark
load  input  1  one-cycle strobe that captures value_in and dp_in into the shadow registers
value_in  input  4*NUM_DIGITS  packed BCD; nibble i belongs to digit i
dp_in  input  NUM_DIGITS  decimal point per digit
lz_suppress  input  1  1 = blank leading zero digits
bcd_out  output  4  digit code to the shared seven-segment decoder
dp_out  output  1  decimal point for the currently shown digit
digit_en_n  output  NUM_DIGITS  active-low digit enables; at most one is low at any time
frame_done  output  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous assert, synchronous release.
- Reset values: state IDLE, digit index 0, slot counter 0, shadow and active registers 0, bcd_out 0, dp_out 0, digit_en_n all ones, frame_done 0.
- Registers:
  - shadow (value, dp) is written on load in any state.
  - active (value, dp) is the only source for displayed data.
  - active <= shadow on every IDLE cycle and on the frame_done cycle.
  - A load in the same cycle as frame_done is applied at the following frame end, because active takes the pre-load shadow.
- States:
  - IDLE:
    - Outputs are at their reset values.
    - enable=1 moves to BLANK with index 0 and counter 0.
  - BLANK:
    - digit_en_n is all ones and dp_out is 0.
    - bcd_out = active nibble[index], so the decoder settles during the guard.
    - After BLANK_CYCLES cycles, moves to SHOW.
  - SHOW:
    - digit_en_n[index] = 0, unless the digit is suppressed.
    - dp_out = active dp[index].
    - bcd_out is unchanged from BLANK.
    - Stays in SHOW for REFRESH_DIV-BLANK_CYCLES cycles, then index increments and the state returns to BLANK.
    - Index wraps from NUM_DIGITS-1 to 0.
- frame_done: asserted during the last SHOW cycle of digit NUM_DIGITS-1. The frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Leading-zero suppression: digit i (i>0) is suppressed when lz_suppress=1 and active nibbles NUM_DIGITS-1 down to i are all zero.
  - A suppressed slot keeps full timing, but its enable stays high and dp_out=0.
  - Digit 0 is never suppressed.
  - A set dp bit does not prevent suppression.
- Invalid codes: nibbles 10..15 pass through unmodified; the decoder renders them as a dash.
- enable=0 in any state: IDLE on the next edge, with outputs blanked and index/counter cleared. The partial frame is abandoned with no frame_done. On re-enable, scanning restarts at digit 0 BLANK.
- Output timing: all outputs come from registers. There is no combinational path from inputs to outputs, and latency from enable rising to the first low enable is 1+BLANK_CYCLES cycles.
- lz_suppress is sampled each cycle; a change takes effect at the next BLANK-to-SHOW transition.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: assert rst_n=0 mid-SHOW -> immediately digit_en_n=4'b1111, bcd_out=0, dp_out=0, frame_done=0; after release, state stays IDLE while enable=0.
- Basic scan: load value 16'h1234 with dp 4'b0100, then enable=1 -> 2 blank cycles, then digit_en_n=1110 with bcd_out=4 for 6 cycles; digit 1 shows 3, digit 2 shows 2 with dp_out=1, digit 3 shows 1; frame_done pulses every 32 cycles.
- Leading zeros: value 16'h0042 with lz_suppress=1 -> digit 2 and digit 3 slots keep enables 1111; digit 1 shows 4, digit 0 shows 2. Value 16'h0000 -> only digit 0 lit, showing 0. With lz_suppress=0, all four digits are lit.
- Tearing: load 16'h5678 during the digit 1 slot of a 16'h1234 frame -> digits 2 and 3 still show 2 and 1; the next frame shows 8,7,6,5. A load on the frame_done cycle -> applied one frame later.
- Enable drop: enable=0 during the digit 2 SHOW slot -> next cycle enables are 1111 and no frame_done occurs; load 16'h9999 while idle, then enable=1 -> digit 0 shows 9 after 3 cycles.
- Invalid code: nibble value 4'hC -> bcd_out=4'hC and the digit enable is asserted normally.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Double-buffers a packed BCD value and drives a shared decoder, digit enables and decimal point.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done
);

    localparam int IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [4*NUM_DIGITS-1:0] active_val_next;
    logic [NUM_DIGITS-1:0]   active_dp_next;
    logic                    frame_end;

    logic [3:0]              bcd_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   en_next;
    logic                    fd_next;

    function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] v,
                                             input logic [IW-1:0]           i);
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IW'(j) == i) r = v[4*j +: 4];
        end
        return r;
    endfunction

    function automatic logic dp_at(input logic [NUM_DIGITS-1:0] d,
                                   input logic [IW-1:0]         i);
        logic r;
        r = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IW'(j) == i) r = d[j];
        end
        return r;
    endfunction

    // Digit i is a leading zero when it and every more significant nibble are zero.
    function automatic logic is_suppressed(input logic [4*NUM_DIGITS-1:0] v,
                                           input logic [IW-1:0]           i,
                                           input logic                    lz);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IW'(j) >= i) && (v[4*j +: 4] != 4'd0)) all_zero = 1'b0;
        end
        return lz && (i != '0) && all_zero;
    endfunction

    assign frame_end = (state == S_SHOW) && (cnt == SHOW_LAST) && (idx == LAST_DIGIT);

    // Active data reloads while idle and at each frame boundary; it takes the pre-load shadow.
    assign active_val_next = ((state == S_IDLE) || frame_end) ? shadow_val : active_val;
    assign active_dp_next  = ((state == S_IDLE) || frame_end) ? shadow_dp  : active_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        if (!enable) begin
            state_next = S_IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_BLANK;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_next = S_SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_next = S_BLANK;
                        cnt_next   = '0;
                        idx_next   = (idx == LAST_DIGIT) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are computed for the upcoming cycle and registered, so nothing is combinational from inputs.
    always_comb begin
        bcd_next = '0;
        dp_next  = 1'b0;
        en_next  = '1;
        fd_next  = 1'b0;
        case (state_next)
            S_BLANK: begin
                bcd_next = nibble_at(active_val_next, idx_next);
            end
            S_SHOW: begin
                bcd_next = nibble_at(active_val_next, idx_next);
                fd_next  = (cnt_next == SHOW_LAST) && (idx_next == LAST_DIGIT);
                if (state == S_SHOW) begin
                    // Suppression is decided once on slot entry and held for the slot.
                    en_next = digit_en_n;
                    dp_next = dp_out;
                end else if (!is_suppressed(active_val_next, idx_next, lz_suppress)) begin
                    dp_next = dp_at(active_dp_next, idx_next);
                    for (int j = 0; j < NUM_DIGITS; j++) begin
                        if (IW'(j) == idx_next) en_next[j] = 1'b0;
                    end
                end
            end
            default: begin
                bcd_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out    <= '0;
            dp_out     <= 1'b0;
            digit_en_n <= '1;
            frame_done <= 1'b0;
        end else begin
            bcd_out    <= bcd_next;
            dp_out     <= dp_next;
            digit_en_n <= en_next;
            frame_done <= fd_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
        end else begin
            if (load) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_in;
            end
            active_val <= active_val_next;
            active_dp  <= active_dp_next;
        end
    end

endmodule
